sponge_squeeze_ctrl: RTL and testbench

- Parametrised squeeze-phase controller for the sponge datapath. Produces an arbitrary-length output stream from the rate portion of the sponge state.
- Emits rate-sized blocks and requests a permutation between blocks over a start/done handshake to an external permutation core (G).
- Final block is partial and masked when the requested length is not a multiple of the rate.
- Sits after the absorb/finalise logic and drives the hash/keystream output stream.

---
 rtl/sponge_squeeze_ctrl.sv | 143 ++++++++++++++
 tb/tb_sponge_squeeze_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sponge_squeeze_ctrl.sv
// sponge_squeeze_ctrl: squeeze-phase controller for the sponge datapath.
// Emits MSB-aligned rate-sized blocks from the state register. Between blocks it
// requests a permutation from an external core over a perm_start/perm_done handshake.
// The final block is masked down to the bits that are still outstanding.
// Optional build macro SQUEEZE_FINAL_PERM_EN: also permute after the last block,
// so state_out holds the permuted state when done pulses.
module sponge_squeeze_ctrl #(
  parameter int unsigned STATE_WIDTH = 320,
  parameter int unsigned RATE_WIDTH  = 64,
  parameter int unsigned LEN_WIDTH   = 20
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [LEN_WIDTH-1:0]               out_len,
  input  logic [STATE_WIDTH-1:0]             state_in,
  output logic                               busy,
  output logic                               perm_start,
  output logic [STATE_WIDTH-1:0]             perm_state_out,
  input  logic [STATE_WIDTH-1:0]             perm_state_in,
  input  logic                               perm_done,
  output logic [RATE_WIDTH-1:0]              out_data,
  output logic [$clog2(RATE_WIDTH+1)-1:0]    out_bits,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic                               done,
  output logic [STATE_WIDTH-1:0]             state_out
);

  localparam int unsigned          BITS_W   = $clog2(RATE_WIDTH + 1);
  localparam logic [LEN_WIDTH-1:0] RATE_LEN = LEN_WIDTH'(RATE_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT,
    S_PERM_REQ,
    S_PERM_WAIT,
    S_DONE
  } state_t;

  state_t                  r_fsm;
  state_t                  w_fsm_nxt;
  logic [STATE_WIDTH-1:0]  r_state;
  logic [LEN_WIDTH-1:0]    r_remaining;
  logic                    w_fits;
  logic                    w_fire;
  logic [BITS_W-1:0]       w_bits;
  logic [RATE_WIDTH-1:0]   w_rate;
  logic [RATE_WIDTH-1:0]   w_mask;

  // Block size: a full rate, or whatever is left when that is no more than a rate.
  assign w_fits = (r_remaining <= RATE_LEN);
  assign w_bits = w_fits ? BITS_W'(r_remaining) : BITS_W'(RATE_WIDTH);
  assign w_fire = (r_fsm == S_EMIT) && out_ready;

  // Rate slice is the MSB end of the state; capacity bits never reach out_data.
  assign w_rate = r_state[STATE_WIDTH-1 -: RATE_WIDTH];
  // out_bits is 0 outside EMIT, so the mask (and out_data) is all-zero there.
  assign w_mask   = ~({RATE_WIDTH{1'b1}} >> out_bits);
  assign out_data = w_rate & w_mask;

  assign busy           = (r_fsm != S_IDLE);
  assign perm_state_out = r_state;
  assign state_out      = r_state;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Next-state and per-state outputs.
  always_comb begin
    w_fsm_nxt  = r_fsm;
    perm_start = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_bits   = '0;
    done       = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (start) begin
          w_fsm_nxt = (out_len == '0) ? S_DONE : S_EMIT;
        end
      end
      S_EMIT: begin
        out_valid = 1'b1;
        out_bits  = w_bits;
        out_last  = w_fits;
        if (out_ready) begin
`ifdef SQUEEZE_FINAL_PERM_EN
          w_fsm_nxt = S_PERM_REQ;
`else
          w_fsm_nxt = w_fits ? S_DONE : S_PERM_REQ;
`endif
        end
      end
      S_PERM_REQ: begin
        perm_start = 1'b1;
        w_fsm_nxt  = S_PERM_WAIT;
      end
      S_PERM_WAIT: begin
        if (perm_done) begin
`ifdef SQUEEZE_FINAL_PERM_EN
          // Nothing left to emit means this was the post-final permutation.
          w_fsm_nxt = (r_remaining == '0) ? S_DONE : S_EMIT;
`else
          w_fsm_nxt = S_EMIT;
`endif
        end
      end
      S_DONE: begin
        done      = 1'b1;
        w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // State register and remaining-length counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= '0;
      r_remaining <= '0;
    end else begin
      if ((r_fsm == S_IDLE) && start) begin
        r_state     <= state_in;
        r_remaining <= out_len;
      end
      if (w_fire) begin
        r_remaining <= r_remaining - LEN_WIDTH'(w_bits);
      end
      if ((r_fsm == S_PERM_WAIT) && perm_done) begin
        r_state <= perm_state_in;
      end
    end
  end

endmodule

// File: tb/tb_sponge_squeeze_ctrl.sv
// Self-checking bench for sponge_squeeze_ctrl: table-driven runs, a reset-abort
// sequence and randomized runs, all checked against a block-level model.
module tb_sponge_squeeze_ctrl;

  localparam int unsigned SW = 320;
  localparam int unsigned RW = 64;
  localparam int unsigned LW = 20;
  localparam int unsigned BW = $clog2(RW + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] out_len;
  logic [SW-1:0] state_in;
  logic          busy;
  logic          perm_start;
  logic [SW-1:0] perm_state_out;
  logic [SW-1:0] perm_state_in;
  logic          perm_done;
  logic [RW-1:0] out_data;
  logic [BW-1:0] out_bits;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          done;
  logic [SW-1:0] state_out;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  sponge_squeeze_ctrl #(
    .STATE_WIDTH (SW),
    .RATE_WIDTH  (RW),
    .LEN_WIDTH   (LW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .out_len        (out_len),
    .state_in       (state_in),
    .busy           (busy),
    .perm_start     (perm_start),
    .perm_state_out (perm_state_out),
    .perm_state_in  (perm_state_in),
    .perm_done      (perm_done),
    .out_data       (out_data),
    .out_bits       (out_bits),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .done           (done),
    .state_out      (state_out)
  );

  typedef struct {
    int unsigned len;
    int unsigned lat;
    int unsigned ready_pct;
    int unsigned stall;
    bit          junk;
    int          tab_blocks;
    int          tab_last;
  } vec_t;

  function automatic void chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Stand-in permutation for the model core: rotate and add round constants.
  function automatic logic [SW-1:0] perm_f(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = {s[SW-14:0], s[SW-1:SW-13]};
    for (int i = 0; i < int'(SW / 32); i++) r[i*32 +: 32] = r[i*32 +: 32] ^ (32'h9E3779B9 + 32'(i));
    return r;
  endfunction

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] r;
    for (int i = 0; i < int'(SW / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},       SW'(busy),       '0);
    chk({tag, "_perm_start"}, SW'(perm_start), '0);
    chk({tag, "_out_valid"},  SW'(out_valid),  '0);
    chk({tag, "_out_last"},   SW'(out_last),   '0);
    chk({tag, "_done"},       SW'(done),       '0);
    chk({tag, "_out_bits"},   SW'(out_bits),   '0);
    chk({tag, "_out_data"},   SW'(out_data),   '0);
    chk({tag, "_state_out"},  state_out,       '0);
  endtask

  // One complete squeeze with a model core of latency lat and a randomized sink.
  task automatic run_one(input int unsigned len, input logic [SW-1:0] st, input int unsigned lat,
                         input int unsigned ready_pct, input int unsigned stall, input bit junk,
                         input int tab_blocks, input int tab_last);
    logic [RW-1:0] e_data[$];
    int unsigned   e_bits[$];
    logic [SW-1:0] s, e_final, cap;
    logic [RW-1:0] m, h_data;
    logic [BW-1:0] h_bits;
    logic          h_last;
    int unsigned   rem, nb, e_perms, b, seen, perms, last_bits, cyc, stalls, cnt;
    bit            pend, fin, ev_n, ep_n, ed_n, hold_n, last_ps, rdy;

    // Expected blocks: successive permutations of st, each rate slice masked.
    s = st; rem = len; nb = 0;
    while (rem > 0) begin
      b = (rem > RW) ? RW : rem;
      m = '0;
      for (int unsigned i = 0; i < b; i++) m[RW-1-i] = 1'b1;
      e_data.push_back(s[SW-1 -: RW] & m);
      e_bits.push_back(b);
      rem = rem - b;
      nb++;
      if (rem > 0) s = perm_f(s);
    end
`ifdef SQUEEZE_FINAL_PERM_EN
    if (nb > 0) s = perm_f(s);
    e_perms = nb;
`else
    e_perms = (nb > 0) ? nb - 1 : 0;
`endif
    e_final = s;

    @(negedge clk);
    start = 1'b1; out_len = LW'(len); state_in = st; out_ready = 1'b0; perm_done = 1'b0;
    ev_n = (len > 0); ed_n = (len == 0); ep_n = 1'b0; hold_n = 1'b0; last_ps = 1'b0;
    pend = 1'b0; seen = 0; perms = 0; last_bits = 0; cyc = 0; stalls = 0; fin = 1'b0; cnt = 0;
    cap = '0; h_data = '0; h_bits = '0; h_last = 1'b0;

    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (ev_n)    chk("valid_latency",      SW'(out_valid),  SW'(1));
      if (ep_n)    chk("perm_start_latency", SW'(perm_start), SW'(1));
      if (ed_n)    chk("done_latency",       SW'(done),       SW'(1));
      if (last_ps) chk("perm_start_width",   SW'(perm_start), SW'(0));
      if (hold_n) begin
        chk("hold_valid", SW'(out_valid), SW'(1));
        chk("hold_data",  SW'(out_data),  SW'(h_data));
        chk("hold_bits",  SW'(out_bits),  SW'(h_bits));
        chk("hold_last",  SW'(out_last),  SW'(h_last));
      end
      chk("busy_high", SW'(busy), SW'(1));
      ev_n = 1'b0; ep_n = 1'b0; ed_n = 1'b0; hold_n = 1'b0; last_ps = perm_start;

      // Stray start requests while busy must be ignored.
      start = 1'b0;
      if (junk && !done && $urandom_range(3) == 0) begin
        start = 1'b1; out_len = LW'($urandom_range(500, 1)); state_in = rand_state();
      end

      // Model permutation core.
      perm_done = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          perm_done = 1'b1; perm_state_in = perm_f(cap); pend = 1'b0;
          if (seen < nb) ev_n = 1'b1;
          else           ed_n = 1'b1;
        end else begin
          cnt--;
        end
      end
      if (perm_start) begin
        perms++; pend = 1'b1; cap = perm_state_out; cnt = lat - 1;
      end

      // Downstream sink.
      rdy = ($urandom_range(99) < ready_pct);
      if (out_valid && stalls < stall) begin rdy = 1'b0; stalls++; end
      out_ready = rdy;
      if (out_valid) begin
        if (rdy) begin
          if (seen < nb) begin
            chk("block_data", SW'(out_data), SW'(e_data[seen]));
            chk("block_bits", SW'(out_bits), SW'(e_bits[seen]));
            chk("block_last", SW'(out_last), SW'(seen == nb - 1));
          end else begin
            chk("block_overrun", SW'(seen), SW'(nb));
          end
          last_bits = out_bits;
          seen++;
`ifdef SQUEEZE_FINAL_PERM_EN
          ep_n = 1'b1;
`else
          if (seen < nb) ep_n = 1'b1;
          else           ed_n = 1'b1;
`endif
        end else begin
          hold_n = 1'b1; h_data = out_data; h_bits = out_bits; h_last = out_last;
        end
      end

      if (done) begin
        chk("blocks",    SW'(seen),  SW'(nb));
        chk("perms",     SW'(perms), SW'(e_perms));
        chk("state_out", state_out,  e_final);
        if (tab_blocks >= 0) chk("tab_blocks",    SW'(seen),      SW'(tab_blocks));
        if (tab_last >= 0)   chk("tab_last_bits", SW'(last_bits), SW'(tab_last));
        fin = 1'b1;
      end
    end
    chk("finished", SW'(fin), SW'(1));
    out_ready = 1'b0; perm_done = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_busy", SW'(busy), SW'(0));
    chk("idle_done", SW'(done), SW'(0));
  endtask

  vec_t tab[8];

  initial begin
    int unsigned cyc;
    reset = 1'b1; start = 1'b0; out_len = '0; state_in = '0;
    perm_state_in = '0; perm_done = 1'b0; out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_zero("post_reset");

    //           len  lat rdy stall junk blocks lastbits
    tab[0] = '{   0,  3, 100, 0, 1'b0,  0, -1};
    tab[1] = '{  64,  3, 100, 0, 1'b0,  1, 64};
    tab[2] = '{ 150,  3, 100, 0, 1'b0,  3, 22};
    tab[3] = '{ 128,  3, 100, 5, 1'b0,  2, 64};
    tab[4] = '{   1,  1, 100, 0, 1'b1,  1,  1};
    tab[5] = '{  65,  1,  50, 0, 1'b1,  2,  1};
    tab[6] = '{ 640,  2,  70, 0, 1'b1, 10, 64};
    tab[7] = '{  63,  4,  60, 2, 1'b1,  1, 63};
    for (int i = 0; i < 8; i++)
      run_one(tab[i].len, rand_state(), tab[i].lat, tab[i].ready_pct, tab[i].stall,
              tab[i].junk, tab[i].tab_blocks, tab[i].tab_last);

    // Reset while waiting on the core, then a late perm_done in IDLE.
    @(negedge clk);
    start = 1'b1; out_len = LW'(150); state_in = rand_state(); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!perm_start && cyc < 50) begin @(negedge clk); cyc++; end
    chk("abort_perm_start_seen", SW'(perm_start), SW'(1));
    repeat (2) @(negedge clk);
    chk("abort_busy_in_wait", SW'(busy), SW'(1));
    reset = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    check_zero("abort_reset");
    reset = 1'b0;
    perm_done = 1'b1; perm_state_in = rand_state();
    @(negedge clk);
    perm_done = 1'b0;
    check_zero("late_done");
    @(negedge clk);
    check_zero("late_done_after");
    run_one(150, rand_state(), 3, 100, 0, 1'b0, 3, 22);

    for (int i = 0; i < 25; i++)
      run_one($urandom_range(700, 0), rand_state(), $urandom_range(5, 1),
              $urandom_range(100, 30), $urandom_range(3, 0), 1'b1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
